// File: rtl/fcs_seq_pkg.sv
// Shared types and sizing for the FCS frame sequencer.
package fcs_seq_pkg;

  typedef enum logic [2:0] {
    S_CLR,
    S_FILL,
    S_RUN,
    S_WAIT,
    S_REPORT
  } state_e;

  localparam int unsigned FIFO_DEPTH = 5;
  localparam int unsigned FCS_BYTES  = 4;
  localparam int unsigned CNT_W      = 3;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fcs_byte_fifo.sv
// Five-entry byte FIFO with occupancy count; push and pop may coincide.
module fcs_byte_fifo
  import fcs_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q, count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fcs_frame_sequencer.sv
// Byte-stream front end for the serial FCS checker: buffers five bytes to find
// the FCS boundary, serializes LSB-first, and reports one status per frame.
module fcs_frame_sequencer
  import fcs_seq_pkg::*;
#(
  parameter int unsigned RESULT_WAIT = 4,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             chk_rst_n,
  output logic             chk_sof,
  output logic             chk_eof,
  output logic             chk_data,
  input  logic             chk_fcs_error,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic             stat_fcs_error,
  output logic             stat_runt,
  output logic             stat_underrun,
  output logic [LEN_W-1:0] stat_len
);

  localparam int unsigned WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count;
  logic [7:0]        fifo_rd;
  logic              push, pop, fifo_clear;
  logic              accept_en, bit_end, fill_pop, run_reload, runt_hit, underrun_hit;
  logic              last_seen_q, last_seen_d, first_q, first_d;
  logic              runt_q, runt_d, underrun_q, underrun_d, err_q, err_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [6:0]        sh_q, sh_d;
  logic [2:0]        bit_q, bit_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              chk_rst_n_q, chk_rst_n_d, chk_sof_q, chk_sof_d;
  logic              chk_eof_q, chk_eof_d, chk_data_q, chk_data_d;

  fcs_byte_fifo u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (fifo_clear),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (pop),
    .data_o  (fifo_rd),
    .count_o (count)
  );

  assign accept_en  = ((state_q == S_FILL) || (state_q == S_RUN)) &&
                      (count < CNT_W'(FIFO_DEPTH)) && !last_seen_q;
  assign push       = in_valid && accept_en;
  assign bit_end    = (state_q == S_RUN) && (bit_q == 3'd7);
  assign fill_pop   = (state_q == S_FILL) && (count == CNT_W'(FIFO_DEPTH));
  assign run_reload = bit_end && ((count == CNT_W'(FIFO_DEPTH)) || (last_seen_q && (count != '0)));
  assign pop        = fill_pop || run_reload;
  assign runt_hit   = (state_q == S_FILL) && push && in_last && (count < CNT_W'(FCS_BYTES));
  assign underrun_hit = bit_end && !run_reload && !(last_seen_q && (count == '0));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_CLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLR:    state_d = S_FILL;
      S_FILL: begin
        if (runt_hit)      state_d = S_REPORT;
        else if (fill_pop) state_d = S_RUN;
      end
      S_RUN: begin
        if (bit_end && !run_reload) state_d = underrun_hit ? S_REPORT : S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_W'(RESULT_WAIT - 1)) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (stat_ready) state_d = S_CLR;
      end
      default:  state_d = S_CLR;
    endcase
  end

  // The popped byte's bit 0 goes straight onto chk_data; the other seven shift out of sh_q.
  always_comb begin
    last_seen_d = last_seen_q;
    first_d     = first_q;
    runt_d      = runt_q;
    underrun_d  = underrun_q;
    err_d       = err_q;
    len_d       = len_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    wcnt_d      = '0;
    chk_rst_n_d = (state_d != S_CLR);
    chk_sof_d   = 1'b0;
    chk_eof_d   = 1'b0;
    chk_data_d  = 1'b0;
    fifo_clear  = (state_q == S_CLR);
    if (state_q == S_CLR) begin
      last_seen_d = 1'b0;
      first_d     = 1'b1;
      runt_d      = 1'b0;
      underrun_d  = 1'b0;
      err_d       = 1'b0;
      len_d       = '0;
      sh_d        = '0;
      bit_d       = '0;
    end
    if (push) begin
      if (len_q != '1) len_d = len_q + 1'b1;
      if (in_last)     last_seen_d = 1'b1;
    end
    if (pop) begin
      chk_data_d = fifo_rd[0];
      sh_d       = fifo_rd[7:1];
      bit_d      = '0;
      chk_sof_d  = first_q;
      first_d    = 1'b0;
      chk_eof_d  = last_seen_q && (count == CNT_W'(FCS_BYTES));
    end else if ((state_q == S_RUN) && !bit_end) begin
      chk_data_d = sh_q[0];
      sh_d       = {1'b0, sh_q[6:1]};
      bit_d      = bit_q + 1'b1;
    end
    if (runt_hit) begin
      runt_d = 1'b1;
      err_d  = 1'b1;
    end
    if (underrun_hit) begin
      underrun_d = 1'b1;
      err_d      = 1'b1;
    end
    if (state_q == S_WAIT) begin
      err_d  = err_q | chk_fcs_error;
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_seen_q <= 1'b0;
      first_q     <= 1'b0;
      runt_q      <= 1'b0;
      underrun_q  <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      wcnt_q      <= '0;
      chk_rst_n_q <= 1'b0;
      chk_sof_q   <= 1'b0;
      chk_eof_q   <= 1'b0;
      chk_data_q  <= 1'b0;
    end else begin
      last_seen_q <= last_seen_d;
      first_q     <= first_d;
      runt_q      <= runt_d;
      underrun_q  <= underrun_d;
      err_q       <= err_d;
      len_q       <= len_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      wcnt_q      <= wcnt_d;
      chk_rst_n_q <= chk_rst_n_d;
      chk_sof_q   <= chk_sof_d;
      chk_eof_q   <= chk_eof_d;
      chk_data_q  <= chk_data_d;
    end
  end

  assign in_ready       = accept_en;
  assign chk_rst_n      = chk_rst_n_q;
  assign chk_sof        = chk_sof_q;
  assign chk_eof        = chk_eof_q;
  assign chk_data       = chk_data_q;
  assign stat_valid     = (state_q == S_REPORT);
  assign stat_fcs_error = err_q;
  assign stat_runt      = runt_q;
  assign stat_underrun  = underrun_q;
  assign stat_len       = len_q;

endmodule

// File: tb/tb_fcs_frame_sequencer.sv
// Directed bench for fcs_frame_sequencer with a bit-serial CRC-32 checker model.
module tb_fcs_frame_sequencer;

  localparam int unsigned RW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, stat_ready = 1'b0;
  logic        in_ready, chk_rst_n, chk_sof, chk_eof, chk_data, chk_fcs_error;
  logic        stat_valid, stat_fcs_error, stat_runt, stat_underrun;
  logic [15:0] stat_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] frm [0:127];

  // checker model / monitor state, written only by the negedge monitor
  logic [31:0] crc = '1;
  logic        active = 1'b0, in_fcs = 1'b0, model_err = 1'b0, sv_prev = 1'b0;
  int cyc = 0, fcs_n = 0, fbits = 0, sof_cnt = 0, eof_cnt = 0;
  int sof_cyc = 0, eof_cyc = 0, last_cyc = 0, rise_cyc = 0;

  fcs_frame_sequencer #(.RESULT_WAIT(RW), .LEN_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .chk_rst_n      (chk_rst_n),
    .chk_sof        (chk_sof),
    .chk_eof        (chk_eof),
    .chk_data       (chk_data),
    .chk_fcs_error  (chk_fcs_error),
    .stat_valid     (stat_valid),
    .stat_ready     (stat_ready),
    .stat_fcs_error (stat_fcs_error),
    .stat_runt      (stat_runt),
    .stat_underrun  (stat_underrun),
    .stat_len       (stat_len)
  );

  always #5 clk = ~clk;

  assign chk_fcs_error = model_err;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (stat_valid && !sv_prev) rise_cyc = cyc;
    sv_prev = stat_valid;
    if (chk_rst_n !== 1'b1) begin
      crc = '1; active = 1'b0; in_fcs = 1'b0; fcs_n = 0; model_err = 1'b0;
    end else begin
      if (chk_sof) begin
        active = 1'b1; in_fcs = 1'b0; fcs_n = 0; crc = '1;
        sof_cnt = sof_cnt + 1; sof_cyc = cyc; fbits = 0;
      end
      if (chk_eof) begin
        eof_cnt = eof_cnt + 1; eof_cyc = cyc; in_fcs = 1'b1;
      end
      if (active) begin
        crc = (crc[0] ^ chk_data) ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        fbits = fbits + 1;
        if (in_fcs) begin
          fcs_n = fcs_n + 1;
          if (fcs_n == 32) begin
            active = 1'b0; last_cyc = cyc; model_err = (crc != 32'hDEBB20E3);
          end
        end
      end
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic build(input int n, input int flip_byte);
    logic [31:0] c;
    logic [7:0]  b;
    c = '1;
    for (int i = 0; i < n - 4; i++) begin
      frm[i] = 8'((i * 29 + 5) & 255);
      b = frm[i];
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm[n - 4 + k] = c[8*k +: 8];
    if (flip_byte >= 0) frm[flip_byte] = frm[flip_byte] ^ 8'h10;
  endtask

  // Sends frm[0..stop_after-1]; with rst_bit>0 returns early once the checker has seen that many bits.
  task automatic send_bytes(input int n, input int stop_after, input int rst_bit);
    int i, budget, sof0;
    i = 0; budget = 0; sof0 = sof_cnt;
    while (i < stop_after && budget < 4000) begin
      if (rst_bit > 0 && sof_cnt != sof0 && fbits >= rst_bit) break;
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = (i == n - 1);
      if (in_ready) i = i + 1;
      tick();
      budget = budget + 1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (budget >= 4000) expect_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_status();
    int budget;
    budget = 0;
    while (!stat_valid && budget < 2000) begin
      tick();
      budget = budget + 1;
    end
    if (!stat_valid) expect_eq("status_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack();
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input int flip_byte,
                           input logic exp_err, input logic do_ack);
    int sof0, eof0;
    build(n, flip_byte);
    sof0 = sof_cnt;
    eof0 = eof_cnt;
    send_bytes(n, n, 0);
    wait_status();
    expect_eq({tag, "_sof_count"}, 32'(sof_cnt - sof0), 32'd1);
    expect_eq({tag, "_eof_count"}, 32'(eof_cnt - eof0), 32'd1);
    expect_eq({tag, "_bit_cycles"}, 32'(last_cyc - sof_cyc + 1), 32'(n * 8));
    expect_eq({tag, "_eof_offset"}, 32'(eof_cyc - sof_cyc), 32'((n - 4) * 8));
    expect_eq({tag, "_latency"}, 32'(rise_cyc - last_cyc), 32'(RW + 1));
    expect_eq({tag, "_fcs_error"}, 32'(stat_fcs_error), 32'(exp_err));
    expect_eq({tag, "_len"}, 32'(stat_len), 32'(n));
    expect_eq({tag, "_runt"}, 32'(stat_runt), 32'd0);
    expect_eq({tag, "_underrun"}, 32'(stat_underrun), 32'd0);
    if (do_ack) ack();
  endtask

  task automatic check_reset_values(input string tag);
    expect_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    expect_eq({tag, "_chk_rst_n"}, 32'(chk_rst_n), 32'd0);
    expect_eq({tag, "_chk_bits"}, 32'({chk_sof, chk_eof, chk_data}), 32'd0);
    expect_eq({tag, "_stat_flags"},
              32'({stat_valid, stat_fcs_error, stat_runt, stat_underrun}), 32'd0);
    expect_eq({tag, "_stat_len"}, 32'(stat_len), 32'd0);
  endtask

  initial begin
    int sof0, hits, lows;

    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    run_frame("good64", 64, -1, 1'b0, 1'b1);
    run_frame("bad64", 64, 10, 1'b1, 1'b1);
    run_frame("min5", 5, -1, 1'b0, 1'b1);

    build(3, -1);
    frm[0] = 8'hA5; frm[1] = 8'h3C; frm[2] = 8'h7E;
    sof0 = sof_cnt;
    send_bytes(3, 3, 0);
    wait_status();
    expect_eq("runt_sof_count", 32'(sof_cnt - sof0), 32'd0);
    expect_eq("runt_flag", 32'(stat_runt), 32'd1);
    expect_eq("runt_fcs_error", 32'(stat_fcs_error), 32'd1);
    expect_eq("runt_len", 32'(stat_len), 32'd3);
    expect_eq("runt_underrun", 32'(stat_underrun), 32'd0);
    ack();

    build(64, -1);
    send_bytes(64, 20, 0);
    repeat (20) tick();
    wait_status();
    expect_eq("underrun_flag", 32'(stat_underrun), 32'd1);
    expect_eq("underrun_fcs_error", 32'(stat_fcs_error), 32'd1);
    expect_eq("underrun_runt", 32'(stat_runt), 32'd0);
    expect_eq("underrun_len", 32'(stat_len), 32'd20);
    ack();
    run_frame("recover64", 64, -1, 1'b0, 1'b1);

    run_frame("b2b_a", 16, -1, 1'b0, 1'b0);
    hits = 0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = frm[0];
      if (in_ready) hits = hits + 1;
      if (!stat_valid) lows = lows + 1;
      tick();
    end
    in_valid = 1'b0;
    expect_eq("b2b_in_ready_held", 32'(hits), 32'd0);
    expect_eq("b2b_stat_valid_held", 32'(lows), 32'd0);
    ack();
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      if (!chk_rst_n) lows = lows + 1;
      tick();
    end
    expect_eq("b2b_chk_rst_pulse", 32'(lows), 32'd1);
    run_frame("b2b_b", 16, -1, 1'b0, 1'b1);

    build(64, -1);
    send_bytes(64, 64, 100);
    expect_eq("midrst_reached_bit", 32'(fbits >= 100), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (stat_valid) hits = hits + 1;
      tick();
    end
    expect_eq("midrst_no_status", 32'(hits), 32'd0);
    run_frame("after_rst64", 64, -1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fcs_frame_sequencer.md
# fcs_frame_sequencer

Byte-stream front end that sequences the serial FCS checker for one receive path. It accepts frames as a byte stream with valid/ready/last and buffers five bytes so it can tell payload from the trailing 4-byte FCS. It serializes each byte LSB-first onto the checker's bit interface with correctly placed start/end-of-frame markers, and re-arms the checker between frames. After each frame it collects the checker verdict and presents one status record per frame on a valid/ready port.

## Interface
- `RESULT_WAIT`, default 4: cycles after the last FCS bit during which `chk_fcs_error` is sampled.
- `LEN_W`, default 16: width of the frame byte counter.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `in_data` in 8: frame byte; payload bytes followed by 4 FCS bytes.
- `in_valid` in 1: byte valid.
- `in_last` in 1: marks the final FCS byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `chk_rst_n` out 1: active-low synchronous reset to the checker.
- `chk_sof` out 1: checker `start_of_frame`, high with the first payload bit.
- `chk_eof` out 1: checker `end_of_frame`, high with the first FCS bit.
- `chk_data` out 1: serial bit to the checker.
- `chk_fcs_error` in 1: checker error output.
- `stat_valid` out 1: status record valid.
- `stat_ready` in 1: status consumer ready.
- `stat_fcs_error` out 1: frame failed the check (also 1 on runt or underrun).
- `stat_runt` out 1: frame had fewer than 5 bytes.
- `stat_underrun` out 1: the input stalled mid-frame and the frame was aborted.
- `stat_len` out `LEN_W`: bytes accepted including FCS; saturates at all-ones.

## Operation
- **States:** CLR, FILL, RUN, WAIT, REPORT.
- **CLR** (one cycle): `chk_rst_n`=0. Clears the byte FIFO, the length counter, the error accumulator and all flags. Goes to FILL.
- **FILL:** `in_ready`=1 while FIFO count<5 and last has not been seen. Accepted bytes are pushed and `stat_len` is incremented.
  - Count reaches 5 without last: pop the oldest byte into the serializer and go to RUN.
  - Last accepted with total ≤4: runt. Go to REPORT with `stat_runt`=1 and `stat_fcs_error`=1. The checker sees no bits.
  - Last accepted with total =5: the same pop as count=5, with `last_seen` set.
- **RUN:** one bit per cycle, LSB first, with no gaps. `in_ready` keeps the FILL rule.
  - `chk_sof`=1 on bit 0 of the first byte only.
  - A popped byte is the first FCS byte when `last_seen` and pre-pop count==4. `chk_eof`=1 on its bit 0 only.
  - At bit 7, reload from the FIFO if count==5 or `last_seen` with count>0.
  - At bit 7 with `last_seen` and count==0: go to WAIT.
  - At bit 7 with count<5 and not `last_seen`: underrun. Go to REPORT with `stat_underrun`=1 and `stat_fcs_error`=1.
- **WAIT:** `chk_data`=0 for `RESULT_WAIT` cycles. `stat_fcs_error` accumulates the OR of `chk_fcs_error` over those cycles. Then go to REPORT.
- **REPORT:** `stat_valid`=1 with all fields stable until `stat_ready`. On handshake go to CLR.
- Throughput: at most one byte per 8 cycles once in RUN. The FIFO holds at most 5 bytes.

## Timing
- Reset values: `in_ready`=0, `chk_rst_n`=0, `chk_sof`=`chk_eof`=`chk_data`=0, all stat outputs 0. The state goes to CLR.
- The first cycle after reset is deasserted is CLR, so every frame starts with a freshly reset checker.
- A reset asserted mid-frame aborts the frame immediately with no status record.
- All `chk_*` outputs are registered. The bit pops on the cycle after the 5th byte handshake and is driven on `chk_data` the following cycle, together with `chk_sof`.
- Latency for frame length N≥5: the last FCS bit is N·8 cycles after the first bit. `stat_valid` rises `RESULT_WAIT`+1 cycles after that last bit.
- Simultaneous push and pop in the same cycle is legal; the count is unchanged.
- `in_last` is ignored unless `in_valid && in_ready`.
- `stat_len` saturates rather than wrapping.

## Structure
- Package `fcs_seq_pkg`: state enum, `FIFO_DEPTH`=5, `FCS_BYTES`=4.
- Sub-module `fcs_byte_fifo`: a 5-deep byte FIFO with count output and simultaneous push/pop.
- The serializer, state machine and status registers live in the top module.

## Test plan
- **Good frame:** 64-byte frame with correct FCS, checker model attached. Expect `chk_sof` once and `chk_eof` once, 512 bit cycles, then a status record with `stat_fcs_error`=0 and `stat_len`=64.
- **Bad frame:** the same frame with one payload bit flipped. Expect `stat_fcs_error`=1, `stat_len`=64, and flags 0.
- **Runt:** 3-byte frame with `in_last` on byte 3. Expect no `chk_sof`, and a status record with `stat_runt`=1, `stat_fcs_error`=1 and `stat_len`=3.
- **Underrun:** drop `in_valid` for 20 cycles mid-payload. Expect `stat_underrun`=1 and `stat_fcs_error`=1, then recovery on the next good frame.
- **Back-to-back:** two good frames with `stat_ready` held low for 10 cycles. Expect `in_ready`=0 until the handshake, a one-cycle `chk_rst_n` low, then the second frame reports 0.
- **Reset mid-frame:** assert `reset` at bit 100. Expect all outputs at their reset values, no status record, and the next frame checked correctly.
